// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin RAM arbiter: state encoding,
// operation codes and a constant-width helper.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB    = 2'd0,
      XFER   = 2'd1,
      RDWAIT = 2'd2
   } arb_state_e;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

   // Index width for N requesters; never narrower than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr,
// wrapping past N-1 back to 0.
module rr_pick #(
   parameter int N  = 16,
   parameter int IW = 4
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      // Walk offsets downward so the smallest offset from ptr is the last write and wins.
      for (int k = N - 1; k >= 0; k--) begin
         if (req_i[(int'(ptr_i) + k) % N]) begin
            valid_o = 1'b1;
            idx_o   = IW'((int'(ptr_i) + k) % N);
         end
      end
      if (valid_o) grant_o[idx_o] = 1'b1;
   end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin sequencer sharing one single-port synchronous RAM between N cores:
// one transaction at a time, registered RAM port, per-core read-data holding registers.
module mem_rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N      = 16,
   parameter int AW     = 8,
   parameter int DW     = 8,
   parameter int RD_LAT = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    rden,
   input  logic [N-1:0]    wren,
   input  logic [N*AW-1:0] Address,
   input  logic [N*DW-1:0] Din,
   input  logic [DW-1:0]   RAMq,
   output logic [N-1:0]    acq,
   output logic [N*DW-1:0] Dq,
   output logic [N-1:0]    rdone,
   output logic [AW-1:0]   RAMAddress,
   output logic [DW-1:0]   RAMDin,
   output logic            RAMwren,
   output logic            busy
);

   localparam int IW     = clog2(N);
   localparam int WCNT_W = 2;

   arb_state_e          state_q, state_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [IW-1:0]       gidx_q, gidx_d;
   logic                op_q, op_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic [AW-1:0]       ram_addr_q, ram_addr_d;
   logic [DW-1:0]       ram_din_q, ram_din_d;
   logic                ram_wren_q, ram_wren_d;
   logic [N-1:0]        rdone_q, rdone_d;
   logic [N*DW-1:0]     dq_q, dq_d;

   logic [N-1:0]        pick_grant;
   logic [IW-1:0]       pick_idx;
   logic                pick_valid;

   rr_pick #(.N(N), .IW(IW)) u_pick (
      .req_i   (rden | wren),
      .ptr_i   (ptr_q),
      .grant_o (pick_grant),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (rst) begin
         state_q    <= ARB;
         ptr_q      <= '0;
         gidx_q     <= '0;
         op_q       <= OP_RD;
         wcnt_q     <= '0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
         ram_wren_q <= 1'b0;
         rdone_q    <= '0;
         // NOTE: Dq is a bank of flops, not a RAM macro, so it is reset like any register.
         dq_q       <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gidx_q     <= gidx_d;
         op_q       <= op_d;
         wcnt_q     <= wcnt_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
         ram_wren_q <= ram_wren_d;
         rdone_q    <= rdone_d;
         dq_q       <= dq_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gidx_d     = gidx_q;
      op_d       = op_q;
      wcnt_d     = wcnt_q;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      ram_wren_d = 1'b0;
      rdone_d    = '0;
      dq_d       = dq_q;
      unique case (state_q)
         ARB: begin
            if (pick_valid) begin
               // A write wins over a simultaneous read from the same core.
               gidx_d     = pick_idx;
               op_d       = (|(wren & pick_grant)) ? OP_WR : OP_RD;
               ram_wren_d = |(wren & pick_grant);
               ram_addr_d = Address[int'(pick_idx) * AW +: AW];
               ram_din_d  = Din[int'(pick_idx) * DW +: DW];
               ptr_d      = IW'((int'(pick_idx) + 1) % N);
               state_d    = XFER;
            end
         end
         XFER: begin
            if (op_q == OP_WR) begin
               state_d = ARB;
            end else begin
               wcnt_d  = WCNT_W'(RD_LAT - 1);
               state_d = RDWAIT;
            end
         end
         RDWAIT: begin
            if (wcnt_q != '0) begin
               wcnt_d = wcnt_q - 1'b1;
            end else begin
               dq_d[int'(gidx_q) * DW +: DW] = RAMq;
               rdone_d[gidx_q]               = 1'b1;
               state_d                       = ARB;
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_comb begin
      acq = '0;
      if (state_q == XFER) acq[gidx_q] = 1'b1;
      busy = (state_q != ARB);
   end

   assign Dq         = dq_q;
   assign rdone      = rdone_q;
   assign RAMAddress = ram_addr_q;
   assign RAMDin     = ram_din_q;
   assign RAMwren    = ram_wren_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Randomised and directed bench for mem_rr_arbiter against a transaction-level
// schedule model and a behavioural single-port RAM.
module tb_mem_rr_arbiter;

   localparam int N      = 16;
   localparam int AW     = 8;
   localparam int DW     = 8;
   localparam int RD_LAT = 1;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    rden, wren;
   logic [N*AW-1:0] addr_bus;
   logic [N*DW-1:0] din_bus;
   logic [DW-1:0]   RAMq;
   logic [N-1:0]    acq, rdone;
   logic [N*DW-1:0] Dq;
   logic [AW-1:0]   RAMAddress;
   logic [DW-1:0]   RAMDin;
   logic            RAMwren, busy;

   always #5 clk = ~clk;

   mem_rr_arbiter #(.N(N), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .rden       (rden),
      .wren       (wren),
      .Address    (addr_bus),
      .Din        (din_bus),
      .RAMq       (RAMq),
      .acq        (acq),
      .Dq         (Dq),
      .rdone      (rdone),
      .RAMAddress (RAMAddress),
      .RAMDin     (RAMDin),
      .RAMwren    (RAMwren),
      .busy       (busy)
   );

   // Behavioural single-port RAM, read-first, one cycle read latency; backdoor for preload.
   logic [DW-1:0] ram_mem [256];
   logic [DW-1:0] ram_q;
   logic          bd_we;
   logic [AW-1:0] bd_addr;
   logic [DW-1:0] bd_data;
   always @(posedge clk) begin
      if (bd_we) ram_mem[bd_addr] <= bd_data;
      else if (RAMwren) ram_mem[RAMAddress] <= RAMDin;
      ram_q <= ram_mem[RAMAddress];
   end
   assign RAMq = ram_q;

   // Transaction-level model: one outstanding transaction, its effects scheduled by cycle number.
   logic [DW-1:0] model_ram [256];
   logic [DW-1:0] model_dq [N];
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   int            m_ptr, arb_free, acq_cyc, acq_core, rd_cyc, rd_core;
   bit            acq_wr;
   logic [DW-1:0] rd_data;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_din;
   bit            auto_drop = 1'b1;
   int            hist [$];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_ptr    = 0;
      arb_free = 0;
      acq_cyc  = -1;
      rd_cyc   = -1;
      exp_addr = '0;
      exp_din  = '0;
      for (int i = 0; i < N; i++) model_dq[i] = '0;
   endtask

   // Decide what the edge closing the current cycle does, from the current inputs.
   task automatic model_issue();
      logic [N-1:0]  req;
      int            w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      req = rden | wren;
      if (rst) begin
         model_reset();
      end else if (cyc >= arb_free && req != '0) begin
         w = -1;
         for (int k = 0; k < N; k++)
            if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
         m_ptr    = (w + 1) % N;
         a        = addr_bus[w*AW +: AW];
         d        = din_bus[w*DW +: DW];
         exp_addr = a;
         exp_din  = d;
         acq_cyc  = cyc + 1;
         acq_core = w;
         acq_wr   = wren[w];
         if (wren[w]) begin
            model_ram[a] = d;
            arb_free     = cyc + 2;
         end else begin
            rd_cyc   = cyc + 2 + RD_LAT;
            rd_core  = w;
            rd_data  = model_ram[a];
            arb_free = rd_cyc;
         end
      end
   endtask

   task automatic check_outputs();
      logic [N-1:0]    one;
      logic [N-1:0]    e_acq, e_rdone;
      logic [N*DW-1:0] e_dq;
      one     = 1;
      e_acq   = '0;
      e_rdone = '0;
      if (cyc == rd_cyc) begin
         model_dq[rd_core] = rd_data;
         e_rdone           = one << rd_core;
      end
      if (cyc == acq_cyc) e_acq = one << acq_core;
      for (int i = 0; i < N; i++) e_dq[i*DW +: DW] = model_dq[i];
      check("acq",     acq,        e_acq);
      check("rdone",   rdone,      e_rdone);
      check("ramwren", RAMwren,    (cyc == acq_cyc) && acq_wr);
      check("busy",    busy,       cyc < arb_free);
      check("ramaddr", RAMAddress, exp_addr);
      check("ramdin",  RAMDin,     exp_din);
      check("dq",      Dq,         e_dq);
      for (int i = 0; i < N; i++) if (acq[i]) hist.push_back(i);
   endtask

   task automatic tick();
      model_issue();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_outputs();
      if (auto_drop && cyc == acq_cyc) begin
         rden[acq_core] = 1'b0;
         wren[acq_core] = 1'b0;
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic req_core(input int c, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      rden[c]             = rd;
      wren[c]             = wr;
      addr_bus[c*AW +: AW] = a;
      din_bus[c*DW +: DW]  = d;
   endtask

   initial begin
      rst      = 1'b1;
      rden     = '0;
      wren     = '0;
      addr_bus = '0;
      din_bus  = '0;
      bd_we    = 1'b0;
      bd_addr  = '0;
      bd_data  = '0;
      model_reset();

      for (int a = 0; a < 256; a++) model_ram[a] = DW'($urandom);
      model_ram[8'h20] = 8'h5A;
      model_ram[8'h30] = 8'h3C;
      model_ram[8'h60] = 8'h9C;

      // Preload the RAM through the backdoor while the arbiter is held in reset.
      bd_we = 1'b1;
      for (int a = 0; a < 256; a++) begin
         bd_addr = AW'(a);
         bd_data = model_ram[a];
         tick();
      end
      bd_we = 1'b0;
      tick();
      rst = 1'b0;

      // Single read, core 3.
      req_core(3, 1'b1, 1'b0, 8'h20, 8'h00);
      ticks(6);
      check("rd3_dq", Dq[3*DW +: DW], 8'h5A);

      // Single write, core 7.
      req_core(7, 1'b0, 1'b1, 8'h11, 8'hC3);
      ticks(4);
      check("wr7_ram", ram_mem[8'h11], 8'hC3);

      // Read/write conflict on core 5: write wins, Dq[5] keeps its earlier read.
      req_core(5, 1'b1, 1'b0, 8'h30, 8'h00);
      ticks(6);
      req_core(5, 1'b1, 1'b1, 8'h40, 8'h77);
      ticks(6);
      check("rw5_dq", Dq[5*DW +: DW], 8'h3C);
      check("rw5_ram", ram_mem[8'h40], 8'h77);

      // Pointer wrap: serve core 13, then 2 and 15 together.
      req_core(13, 1'b0, 1'b1, 8'h50, 8'hD1);
      ticks(4);
      hist.delete();
      req_core(2, 1'b1, 1'b0, 8'h21, 8'h00);
      req_core(15, 1'b1, 1'b0, 8'h22, 8'h00);
      ticks(10);
      check("wrap_cnt", hist.size(), 2);
      check("wrap_first", (hist.size() > 0) ? hist[0] : -1, 15);
      check("wrap_second", (hist.size() > 1) ? hist[1] : -1, 2);

      // Reset during RDWAIT of a read for core 9.
      req_core(9, 1'b1, 1'b0, 8'h60, 8'h00);
      ticks(6);
      check("rd9_dq", Dq[9*DW +: DW], 8'h9C);
      req_core(9, 1'b1, 1'b0, 8'h60, 8'h00);
      ticks(2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_dq9", Dq[9*DW +: DW], 8'h00);
      check("rst_acq", acq, 16'h0000);
      check("rst_rdone", rdone, 16'h0000);
      check("rst_wren", RAMwren, 1'b0);
      check("rst_busy", busy, 1'b0);

      // Fairness: all cores read continuously from ptr 0.
      for (int i = 0; i < N; i++) addr_bus[i*AW +: AW] = AW'(8'h70 + i);
      hist.delete();
      auto_drop = 1'b0;
      rden      = '1;
      ticks(48);
      rden      = '0;
      auto_drop = 1'b1;
      ticks(4);
      check("fair_cnt", hist.size(), 16);
      for (int k = 0; k < N; k++)
         check("fair_order", (hist.size() > k) ? hist[k] : -1, k);

      // Random traffic, including occasional resets and withdrawn requests.
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 499) == 0);
         for (int i = 0; i < N; i++) begin
            if (!rden[i] && !wren[i]) begin
               if ($urandom_range(0, 7) == 0) begin
                  case ($urandom_range(0, 2))
                     0:       req_core(i, 1'b1, 1'b0, AW'($urandom_range(0, 31)), DW'($urandom));
                     1:       req_core(i, 1'b0, 1'b1, AW'($urandom_range(0, 31)), DW'($urandom));
                     default: req_core(i, 1'b1, 1'b1, AW'($urandom_range(0, 31)), DW'($urandom));
                  endcase
               end
            end else if ($urandom_range(0, 63) == 0) begin
               rden[i] = 1'b0;
               wren[i] = 1'b0;
            end
         end
         tick();
      end
      rst  = 1'b0;
      rden = '0;
      wren = '0;
      ticks(8);

      begin
         int diffs;
         diffs = 0;
         for (int a = 0; a < 256; a++) if (ram_mem[a] !== model_ram[a]) diffs++;
         check("ram_final", diffs, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port synchronous RAM (DRAM or IRAM instance) between N processor cores.
- Each core raises a read or write request. The block grants one core per transaction, drives the RAM port from registers, waits out the RAM read latency, and returns read data to a per-core holding register.
- It sits between the core array and the RAM macro, one instance per shared memory.

Parameters:
- N, 16, number of requesting cores.
- AW, 8, address width.
- DW, 8, data width.
- RD_LAT, 1, cycles from the edge that latches the RAM address until RAMq is valid to sample; legal range 1..3.

Ports:
- clk  in  1  single clock for the block and the RAM.
- rst  in  1  synchronous, active-high reset.
- rden  in  N  per-core read request; level, held by the core until acq.
- wren  in  N  per-core write request; level, held by the core until acq.
- Address  in  N*AW  concatenated core addresses; core i occupies [i*AW +: AW].
- Din  in  N*DW  concatenated core write data; core i occupies [i*DW +: DW].
- RAMq  in  DW  RAM read data.
- acq  out  N  one-hot grant; pulses for exactly one cycle per transaction.
- Dq  out  N*DW  per-core read-data holding registers.
- rdone  out  N  one-hot, one-cycle pulse when Dq slice i is updated.
- RAMAddress  out  AW  registered RAM address.
- RAMDin  out  DW  registered RAM write data.
- RAMwren  out  1  registered RAM write enable.
- busy  out  1  high whenever state is not ARB.

Behaviour:
- Reset values: state=ARB, ptr=0, acq=0, rdone=0, RAMwren=0, RAMAddress=0, RAMDin=0, every Dq slice=0, busy=0.
- State ARB:
  - req = rden | wren.
  - If req==0, stay in ARB with no outputs changing.
  - Otherwise winner w = first set bit scanning from ptr upward, wrapping past N-1 to 0.
  - Register gidx=w, op=wren[w] (a write takes precedence if both bits are set; the read is dropped), RAMAddress=Address[w], RAMDin=Din[w], RAMwren=wren[w].
  - Set ptr=(w+1) mod N and go to XFER.
- State XFER (one cycle):
  - acq[gidx]=1, all other acq bits 0; RAM sees the registered address, data and enable.
  - Write: the RAM commits at the end of this cycle. Next cycle RAMwren=0, state=ARB.
  - Read: RAMwren stays 0, load wcnt=RD_LAT-1, go to RDWAIT.
- State RDWAIT:
  - While wcnt!=0, decrement wcnt.
  - When wcnt==0, at the end of this cycle: Dq[gidx]<=RAMq, rdone[gidx]=1 (registered, visible next cycle), state=ARB.
- Timing with RD_LAT=1, request seen in ARB at cycle t:
  - acq at t+1.
  - Write committed at the end of t+1.
  - Read data in Dq and rdone high at t+3.
- Throughput: a write takes 2 cycles; a read takes 2+RD_LAT cycles.
- Requests are sampled only in ARB. Changes during XFER/RDWAIT are ignored. A request withdrawn before its grant is simply not served.
- A core must drop its request in the cycle after acq, or it is re-queued and served again at its next turn.
- Fairness: with all N requesting continuously, each core is granted exactly once per N transactions, in ascending order from ptr.
- Dq slices hold their value until overwritten by a later read for the same core; other slices are never disturbed.
- Reset mid-transaction: the next edge forces all reset values. RAMwren drops that edge; a pending read is abandoned (no rdone, Dq cleared).
- No combinational path from rden/wren/Address to any output.

Decomposition:
- Shared package mem_arb_pkg holds:
  - State encoding: ARB=2'd0, XFER=2'd1, RDWAIT=2'd2 (2'd3 is illegal and recovers to ARB).
  - Constant OP_RD=1'b0, OP_WR=1'b1.
  - Function clog2 for the gidx/ptr width.
- One sub-module, rr_pick: combinational rotating priority picker. Inputs req[N] and ptr; outputs one-hot/index winner and valid.

Test Plan:
- Single read: after reset, core 3 rden=1, Address=8'h20, RAM holds 8'h5A → acq[3] at t+1, RAMwren=0, RAMAddress=8'h20, Dq[3]=8'h5A and rdone[3]=1 at t+3.
- Single write: core 7 wren=1, Address=8'h11, Din=8'hC3 → acq[7] and RAMwren=1 for exactly one cycle at t+1, then RAM[8'h11]=8'hC3, busy low at t+2.
- Round-robin fairness: all 16 cores hold rden until acq and re-request immediately → grant order 0,1,…,15,0 with no core granted twice within 16 grants; 16 reads take 48 cycles.
- Pointer wrap and priority: ptr=14 after serving core 13; cores 2 and 15 request → 15 granted first, then 2.
- Read/write conflict: core 5 with rden=wren=1, Din=8'h77 → treated as a write, no rdone[5], Dq[5] unchanged.
- Reset mid-read: assert rst during RDWAIT for core 9 → next cycle acq=0, rdone=0, RAMwren=0, Dq[9]=0, state ARB, ptr=0.
